// File: rtl/act_pwl_pkg.sv
`default_nettype none
// ============================================================================
// Module : act_pwl_pkg
// Brief  : Shared constants, segment entry type and saturation helper for the
//          programmable piecewise-linear activation unit.
// Rev    : 1.0
// ============================================================================
package act_pwl_pkg;

  localparam int C_DATA_W  = 16;
  localparam int C_FRAC_W  = 8;
  localparam int C_SEG_N   = 16;
  localparam int C_SHIFT_W = 5;

  typedef struct packed {
    logic [C_DATA_W-1:0]  bp;
    logic [C_SHIFT_W-1:0] shift;
    logic [C_DATA_W-1:0]  bias;
    logic                 zero;
  } seg_t;

  localparam seg_t C_SEG_RST = '{bp: '0, shift: '0, bias: '0, zero: 1'b1};

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/act_pwl_segsel.sv
`default_nettype none
// ============================================================================
// Module : act_pwl_segsel
// Brief  : Thermometer comparator returning the highest segment index whose
//          breakpoint does not exceed the sample (0 when below all).
// Rev    : 1.0
// ============================================================================
module act_pwl_segsel
  import act_pwl_pkg::*;
#(
  parameter int DATA_W = C_DATA_W,
  parameter int SEG_N  = C_SEG_N,
  parameter int IDX_W  = $clog2(SEG_N)
) (
  input  logic [DATA_W-1:0]            xm,
  input  logic [SEG_N-1:0][DATA_W-1:0] bp,
  output logic [IDX_W-1:0]             k
);

  logic [SEG_N-1:0] w_ge;

  for (genvar i = 0; i < SEG_N; i++) begin : g_cmp
    assign w_ge[i] = ($signed(xm) >= $signed(bp[i]));
  end

  // Entry 0 is the fallback, so its comparison result never matters.
  always_comb begin
    k = '0;
    for (int i = 1; i < SEG_N; i++) begin
      if (w_ge[i]) k = IDX_W'(i);
    end
  end

  logic w_unused_ge0;
  assign w_unused_ge0 = w_ge[0];

endmodule
`default_nettype wire

// File: rtl/act_pwl_pipe.sv
`default_nettype none
// ============================================================================
// Module : act_pwl_pipe
// Brief  : Three-stage streaming piecewise-linear activation with a runtime
//          loadable segment table, odd symmetry and output saturation.
// Rev    : 1.0
// ============================================================================
module act_pwl_pipe
  import act_pwl_pkg::*;
#(
  parameter int DATA_W  = C_DATA_W,
  parameter int FRAC_W  = C_FRAC_W,
  parameter int SEG_N   = C_SEG_N,
  parameter int SHIFT_W = C_SHIFT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_x,
  input  logic                       in_odd,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_y,
  input  logic                       cfg_we,
  input  logic [$clog2(SEG_N)-1:0]   cfg_addr,
  input  logic [DATA_W-1:0]          cfg_bp,
  input  logic [SHIFT_W-1:0]         cfg_shift,
  input  logic [DATA_W-1:0]          cfg_bias,
  input  logic                       cfg_zero
);

  localparam int IDX_W = $clog2(SEG_N);

  // The binary point position never enters the datapath arithmetic.
  if (FRAC_W > DATA_W) begin : g_frac_unused
  end

  typedef struct packed {
    logic [DATA_W-1:0]  bp;
    logic [SHIFT_W-1:0] shift;
    logic [DATA_W-1:0]  bias;
    logic               zero;
  } entry_t;

  localparam entry_t c_rst_entry = '{bp: '0, shift: '0, bias: '0, zero: C_SEG_RST.zero};

  entry_t                       r_tbl [SEG_N];
  logic [SEG_N-1:0][DATA_W-1:0] w_bp;
  logic [IDX_W-1:0]             w_k;
  entry_t                       w_sel;
  logic [DATA_W-1:0]            w_xm;
  logic                         w_en;

  logic                         r1_valid, r1_odd, r1_zero;
  logic [DATA_W-1:0]            r1_xm, r1_bp, r1_bias;
  logic [SHIFT_W-1:0]           r1_shift;
  logic                         r2_valid, r2_odd, r2_zero;
  logic [DATA_W:0]              r2_t;
  logic [DATA_W-1:0]            r2_bias;
  logic                         r_out_valid;
  logic [DATA_W-1:0]            r_out_y;

  logic signed [DATA_W:0]       w_d, w_t;
  logic signed [DATA_W+1:0]     w_sum, w_s;
  logic [DATA_W-1:0]            w_y;

  assign w_en      = ~r_out_valid | out_ready;
  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign out_y     = r_out_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SEG_N; i++) r_tbl[i] <= c_rst_entry;
    end else if (cfg_we) begin
      r_tbl[cfg_addr] <= '{bp: cfg_bp, shift: cfg_shift, bias: cfg_bias, zero: cfg_zero};
    end
  end

  for (genvar i = 0; i < SEG_N; i++) begin : g_bp
    assign w_bp[i] = r_tbl[i].bp;
  end

  // |most-negative| has no positive twin, so it folds onto max positive.
  always_comb begin
    w_xm = in_x;
    if (in_odd && in_x[DATA_W-1]) begin
      if (in_x == {1'b1, {(DATA_W-1){1'b0}}}) w_xm = {1'b0, {(DATA_W-1){1'b1}}};
      else                                     w_xm = -in_x;
    end
  end

  act_pwl_segsel #(
    .DATA_W (DATA_W),
    .SEG_N  (SEG_N),
    .IDX_W  (IDX_W)
  ) u_segsel (
    .xm (w_xm),
    .bp (w_bp),
    .k  (w_k)
  );

  assign w_sel = r_tbl[w_k];

  assign w_d = $signed({r1_xm[DATA_W-1], r1_xm}) - $signed({r1_bp[DATA_W-1], r1_bp});
  assign w_t = w_d >>> r1_shift;

  assign w_sum = $signed({r2_t[DATA_W], r2_t}) + $signed({{2{r2_bias[DATA_W-1]}}, r2_bias});

  always_comb begin
    w_s = w_sum;
    if (r2_odd)  w_s = -w_sum;
    if (r2_zero) w_s = '0;
  end

  assign w_y = DATA_W'(sat({{(62-DATA_W){w_s[DATA_W+1]}}, w_s}, DATA_W));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid    <= 1'b0;
      r1_odd      <= 1'b0;
      r1_zero     <= 1'b0;
      r1_xm       <= '0;
      r1_bp       <= '0;
      r1_bias     <= '0;
      r1_shift    <= '0;
      r2_valid    <= 1'b0;
      r2_odd      <= 1'b0;
      r2_zero     <= 1'b0;
      r2_t        <= '0;
      r2_bias     <= '0;
      r_out_valid <= 1'b0;
      r_out_y     <= '0;
    end else if (w_en) begin
      r1_valid    <= in_valid;
      r1_odd      <= in_odd;
      r1_zero     <= w_sel.zero;
      r1_xm       <= w_xm;
      r1_bp       <= w_sel.bp;
      r1_bias     <= w_sel.bias;
      r1_shift    <= w_sel.shift;
      r2_valid    <= r1_valid;
      r2_odd      <= r1_odd;
      r2_zero     <= r1_zero;
      r2_t        <= w_t;
      r2_bias     <= r1_bias;
      r_out_valid <= r2_valid;
      if (r2_valid) r_out_y <= w_y;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_act_pwl_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_act_pwl_pipe
// Brief  : Self-checking bench: directed curve points plus randomized traffic
//          scored against an arithmetic model of the activation.
// Rev    : 1.0
// ============================================================================
module tb_act_pwl_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic        in_odd = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_y;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_addr = '0;
  logic [15:0] cfg_bp = '0;
  logic [4:0]  cfg_shift = '0;
  logic [15:0] cfg_bias = '0;
  logic        cfg_zero = 1'b0;

  act_pwl_pipe #(.DATA_W(16), .FRAC_W(8), .SEG_N(16), .SHIFT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_odd    (in_odd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_bp    (cfg_bp),
    .cfg_shift (cfg_shift),
    .cfg_bias  (cfg_bias),
    .cfg_zero  (cfg_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_out = 0;
  int m_bp [16];
  int m_sh [16];
  int m_bias [16];
  int m_zero [16];
  logic [15:0] exp_q [$];
  logic [15:0] hist [$];
  logic [15:0] last_y = '0;
  logic [15:0] hold_y = '0;
  logic        stall_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_bp[i] = 0; m_sh[i] = 0; m_bias[i] = 0; m_zero[i] = 1;
    end
  endtask

  // Activation computed with plain integers straight from the curve definition.
  function automatic logic [15:0] model(input logic [15:0] x, input logic odd);
    int xm, k, d, t, s;
    xm = int'($signed(x));
    if (odd && xm < 0) xm = (xm == -32768) ? 32767 : -xm;
    k = 0;
    for (int i = 0; i < 16; i++) if (xm >= m_bp[i]) k = i;
    d = xm - m_bp[k];
    t = d >>> m_sh[k];
    s = t + m_bias[k];
    if (odd) s = -s;
    if (m_zero[k] != 0) s = 0;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_reset();
      stall_prev = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (stall_prev) begin
        chk("stall_valid_hold", out_valid, 1);
        chk("stall_y_hold", out_y, hold_y);
      end
      if (in_valid && in_ready) exp_q.push_back(model(in_x, in_odd));
      if (cfg_we) begin
        m_bp[cfg_addr]   = int'($signed(cfg_bp));
        m_sh[cfg_addr]   = int'(cfg_shift);
        m_bias[cfg_addr] = int'($signed(cfg_bias));
        m_zero[cfg_addr] = int'(cfg_zero);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
        else chk("out_y", out_y, exp_q.pop_front());
        last_y = out_y;
        hist.push_back(out_y);
        n_out++;
      end
      stall_prev = out_valid && !out_ready;
      hold_y = out_y;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] bp, input logic [4:0] sh,
                           input logic [15:0] bias, input logic z);
    cfg_we = 1'b1; cfg_addr = a; cfg_bp = bp; cfg_shift = sh; cfg_bias = bias; cfg_zero = z;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [15:0] x, input logic odd);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_x = x; in_odd = odd;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("send_timeout", 0, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    int lat, base;
    m_reset();
    repeat (3) tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 16'h0000);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    cfg_write(4'd0, 16'h0000, 5'd0, 16'h0000, 1'b0);
    cfg_write(4'd1, 16'h0118, 5'd1, 16'h0118, 1'b0);
    cfg_write(4'd2, 16'h0228, 5'd2, 16'h01A0, 1'b0);
    for (int i = 3; i < 16; i++) cfg_write(4'(i), 16'h7FFF, 5'd0, 16'h0000, 1'b1);

    chk("model_pin_basic", model(16'h0080, 1'b0), 16'h0080);
    chk("model_pin_seg1", model(16'h0200, 1'b0), 16'h018C);
    chk("model_pin_odd", model(16'hFE00, 1'b1), 16'hFE74);
    chk("model_pin_minneg", model(16'h8000, 1'b1), 16'h0000);

    send(16'h0080, 1'b0);
    lat = 1;
    while (!out_valid && lat < 10) begin tick(); lat++; end
    chk("latency", lat, 3);
    chk("basic_y", out_y, 16'h0080);
    drain();

    send(16'h0200, 1'b0); drain(); chk("seg1_y", last_y, 16'h018C);
    send(16'hFE00, 1'b1); drain(); chk("odd_y", last_y, 16'hFE74);
    send(16'h8000, 1'b1); drain(); chk("minneg_odd_y", last_y, 16'h0000);

    cfg_write(4'd1, 16'h0118, 5'd1, 16'h7FF0, 1'b0);
    chk("model_pin_satpos", model(16'h0200, 1'b0), 16'h7FFF);
    chk("model_pin_satneg", model(16'hFE00, 1'b1), 16'h8000);
    send(16'h0200, 1'b0); drain(); chk("sat_pos_y", last_y, 16'h7FFF);
    send(16'hFE00, 1'b1); drain(); chk("sat_neg_y", last_y, 16'h8000);

    base = n_out;
    fork
      for (int i = 0; i < 8; i++) send(16'($urandom_range(0, 16'h0300)), 1'($urandom_range(0, 1)));
      begin
        repeat (4) tick();
        out_ready = 1'b0;
        repeat (4) tick();
        out_ready = 1'b1;
      end
    join
    drain();
    chk("backpressure_count", n_out - base, 8);

    in_valid = 1'b1; in_x = 16'h0200; in_odd = 1'b0;
    cfg_we = 1'b1; cfg_addr = 4'd1; cfg_bp = 16'h0118; cfg_shift = 5'd1;
    cfg_bias = 16'h0050; cfg_zero = 1'b0;
    tick();
    cfg_we = 1'b0;
    tick();
    in_valid = 1'b0;
    drain();
    chk("hazard_old_bias", hist[hist.size()-2], 16'h7FFF);
    chk("hazard_new_bias", last_y, 16'h00C4);

    for (int c = 0; c < 500; c++) begin
      logic [15:0] bp_keep;
      int a;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_x      = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h0400));
      if ($urandom_range(0, 3) == 0) in_x = -in_x;
      in_odd    = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 19) == 0);
      a         = $urandom_range(0, 15);
      bp_keep   = m_bp[a][15:0];
      cfg_addr  = 4'(a);
      cfg_bp    = bp_keep;
      cfg_shift = 5'($urandom_range(0, 31));
      cfg_bias  = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 16'h0200));
      cfg_zero  = ($urandom_range(0, 7) == 0);
      tick();
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    drain();

    in_valid = 1'b1; in_x = 16'h0100; in_odd = 1'b0;
    repeat (4) tick();
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_y", out_y, 16'h0000);
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    base = n_out;
    repeat (5) tick();
    chk("no_output_after_reset", n_out - base, 0);
    send(16'h0200, 1'b0);
    drain();
    chk("reset_table_y", last_y, 16'h0000);
    chk("reset_table_count", n_out - base, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
